// File: rtl/thto_to_bin.sv
// thto_to_bin: sequential packed-BCD to unsigned binary converter.
// Each clock performs one reverse double-dabble step. A conversion starts
// with an i_Start/o_Done handshake.
//
// Handshake: i_Start is a request that is sampled only while idle
// (o_Busy=0). The edge that samples i_Start=1 also captures i_Bcd. A request
// made while o_Busy=1 is dropped and is not queued. Completion is a single
// o_Done cycle. o_Bin and o_Err are valid during that cycle and hold
// afterwards: o_Bin until the next completion, o_Err until the next accepted
// start.
module thto_to_bin #(
  parameter int DIGITS = 4,
  parameter int BW     = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_Start,
  input  logic [4*DIGITS-1:0]   i_Bcd,
  output logic [BW-1:0]         o_Bin,
  output logic                  o_Done,
  output logic                  o_Busy,
  output logic                  o_Err
);

  localparam int CW = $clog2(BW + 1);
  localparam int RW = 4 * DIGITS + BW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [RW-1:0]   r, r_n;        // {bcd_field, bin_field}
  logic [CW-1:0]   cnt, cnt_n;
  logic [BW-1:0]   bin, bin_n;
  logic            err, err_n;
  logic [RW-1:0]   shifted;
  logic [RW-1:0]   corrected;
  logic            bad_digit;

  // State, working register, step counter and held results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r     <= '0;
      cnt   <= '0;
      bin   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      r     <= r_n;
      cnt   <= cnt_n;
      bin   <= bin_n;
      err   <= err_n;
    end
  end

  // One reverse double-dabble step: shift right, then any nibble >= 8 drops by 3.
  always_comb begin
    shifted   = r >> 1;
    corrected = shifted;
    for (int d = 0; d < DIGITS; d++) begin
      if (shifted[BW + 4*d + 3]) begin
        corrected[BW + 4*d +: 4] = shifted[BW + 4*d +: 4] - 4'd3;
      end
    end
  end

  // Any operand nibble above 9 makes the request invalid.
  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (i_Bcd[4*d +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_n = state;
    r_n     = r;
    cnt_n   = cnt;
    bin_n   = bin;
    err_n   = err;
    case (state)
      IDLE: begin
        if (i_Start) begin
          if (bad_digit) begin
            err_n   = 1'b1;
            bin_n   = '0;
            state_n = DONE;
          end else begin
            r_n     = {i_Bcd, {BW{1'b0}}};
            cnt_n   = '0;
            err_n   = 1'b0;
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        r_n   = corrected;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(BW - 1)) begin
          bin_n   = corrected[BW-1:0];
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign o_Bin  = bin;
  assign o_Err  = err;
  assign o_Done = (state == DONE);
  assign o_Busy = (state == SHIFT) || (state == DONE);

endmodule

// File: doc/thto_to_bin.md
Name: thto_to_bin

Overview:
- Sequential BCD-to-binary converter. It takes a packed BCD value (units, tens, hundreds, thousands) and returns its unsigned binary equivalent.
- Sits on the input path of the MDR datapath. It converts operands entered as decimal digits into binary before they reach the multiplier/divider/root core.
- It is the inverse of the binary-to-thousands/hundreds/tens/ones splitter.
- Uses iterative reverse double-dabble: one shift-and-correct step per clock, under a start/done handshake.

Parameters:
- DIGITS, 4, number of BCD digits in i_Bcd. Digit 0 (units) is in bits [3:0].
- BW, 14, width of the binary result. Must satisfy 10^DIGITS - 1 < 2^BW.
- CW, $clog2(BW+1), width of the internal step counter (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- i_Start  input  1  conversion request. Sampled only in IDLE.
- i_Bcd  input  4*DIGITS  packed BCD operand. Sampled on the edge that accepts i_Start.
- o_Bin  output  BW  binary result. Held until the next completion.
- o_Done  output  1  one-cycle completion pulse.
- o_Busy  output  1  high while a conversion is in progress (states SHIFT and DONE).
- o_Err  output  1  invalid-digit flag. Valid while o_Done is high; held until the next accepted start.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (rst).
- Reset: state=IDLE. o_Bin=0, o_Done=0, o_Busy=0, o_Err=0. Counter=0, internal shift register=0.
- Reset overrides everything, including a conversion in progress. The partial result is discarded, no o_Done is issued, and a new start is accepted the first cycle after rst deasserts.
- Internal register R is 4*DIGITS+BW bits: {bcd_field, bin_field}.
- State IDLE, on edge with i_Start=1:
  - Invalid-digit check: if any i_Bcd nibble > 9, go to DONE, set o_Err=1, load o_Bin=0.
  - Otherwise load R={i_Bcd, BW'b0}, counter=0, clear o_Err, go to SHIFT.
- State IDLE, i_Start=0: remain in IDLE. o_Bin and o_Err hold.
- State SHIFT, each edge:
  - Shift R right by 1 (zero into the MSB).
  - Then, for every BCD nibble of the shifted value: if the nibble >= 8, subtract 3 (4-bit, no borrow across nibbles).
  - Counter increments.
  - When counter reaches BW-1 (the BW-th shift), load o_Bin with bin_field of the post-shift value, set o_Done=1, go to DONE.
- State DONE: o_Done=1 for exactly this one cycle. On the next edge, o_Done=0 and go to IDLE.
- Latency: start accepted at edge k; o_Done is high in the cycle after edge k+BW, i.e. BW cycles (14 by default). The invalid-digit path completes in 1 cycle.
- Throughput: a new i_Start is accepted in the IDLE cycle after DONE. Back-to-back conversions take BW+2 cycles each.
- i_Start while o_Busy=1 (SHIFT or DONE) is ignored. It is not queued, and i_Bcd changes during a conversion have no effect.
- After BW steps, bcd_field is zero for all valid inputs. It is not checked.
- Arithmetic: unsigned only. Maximum result 10^DIGITS-1 (9999 = 14'h270F).

Test Plan:
- Reset then i_Bcd=16'h0000, i_Start pulse -> o_Done at cycle 14, o_Bin=0, o_Err=0.
- i_Bcd=16'h1234, i_Start pulse -> o_Done exactly 14 cycles after acceptance for one cycle, o_Bin=14'd1234 (14'h04D2). o_Bin holds after o_Done falls.
- i_Bcd=16'h9999 -> o_Bin=14'h270F. Then i_Bcd=16'h0001 -> o_Bin=1. Then 16'h0010 -> o_Bin=10 (nibble carry boundaries).
- i_Bcd=16'h12A4 -> o_Done 1 cycle after acceptance, o_Err=1, o_Bin=0. A following valid start (16'h0042) clears o_Err, and o_Bin=42.
- Start 16'h0500, then assert i_Start with 16'h0777 at cycle 5 -> ignored; o_Bin=500. Hold i_Start high continuously -> a new conversion every 16 cycles, o_Done pulses never adjacent.
- Start 16'h8888, assert rst at cycle 7 for one cycle -> no o_Done, all outputs 0 after the reset edge. A new start with 16'h0003 gives o_Bin=3 after 14 cycles.
